// File: rtl/rocc_dispatch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rocc_dispatch_unit_pkg
// Description : Shared types and constants for the RoCC dispatch unit:
//               issue-stage operand bundle, write-back exception record,
//               buffered command entry and response-tracking tag entry.
// Revision    : 1.0 - initial release
// ============================================================================
package rocc_dispatch_unit_pkg;

    localparam int c_XLEN        = 64;
    localparam int TRANS_ID_BITS = 3;
    localparam int ROCC_XD_BIT   = 14;

    localparam logic [c_XLEN-1:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [c_XLEN-1:0]        operand_a;
        logic [c_XLEN-1:0]        operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [c_XLEN-1:0] cause;
        logic [c_XLEN-1:0] tval;
        logic              valid;
    } exception_t;

    typedef struct packed {
        logic [31:0]              instr;
        logic [c_XLEN-1:0]        rs1;
        logic [c_XLEN-1:0]        rs2;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     xd;
    } rocc_cmd_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [4:0]               rd;
        logic                     squash;
    } rocc_tag_t;

endpackage
`default_nettype wire

// File: rtl/rocc_dispatch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rocc_fifo
// Description : Small synchronous FIFO with type parameter, first-word
//               fall-through head and a synchronous flush.
// Ports       : clk_i, rst_ni (async active-low), flush_i (clears all
//               entries), push_i/data_i, pop_i/data_o, full_o, empty_o,
//               count_o (occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
module rocc_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_IW = (c_AW > 0) ? c_AW : 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic [c_IW-1:0] w_wr_idx;
    logic [c_IW-1:0] w_rd_idx;
    logic w_push;
    logic w_pop;
    T     r_mem [DEPTH];

    generate
        if (c_AW > 0) begin : g_idx_multi
            assign w_wr_idx = r_wr_ptr[c_AW-1:0];
            assign w_rd_idx = r_rd_ptr[c_AW-1:0];
        end else begin : g_idx_single
            assign w_wr_idx = 1'b0;
            assign w_rd_idx = 1'b0;
        end
    endgenerate

    assign count_o = r_wr_ptr - r_rd_ptr;
    assign full_o  = (count_o == (c_AW + 1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign data_o  = r_mem[w_rd_idx];

    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[w_wr_idx] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/rocc_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module      : rocc_dispatch_unit
// Description : Buffers RoCC commands from the issue stage, drives the
//               accelerator command channel, tracks responses owed by xd=1
//               instructions (in order) and returns results on a registered
//               write-back port. xd=0 instructions write back zero once the
//               accelerator accepts their command.
// Ports       : clk_i, rst_ni (async active-low), flush_i
//               rocc_valid_i/rocc_ready_o/rocc_instr_i/fu_data_i : issue side
//               cmd_valid_o/cmd_ready_i/cmd_instr_o/cmd_rs1_o/cmd_rs2_o
//               resp_valid_i/resp_ready_o/resp_rd_i/resp_data_i
//               wb_valid_o/wb_trans_id_o/wb_result_o/wb_exception_o
//               busy_o
// Options     : ROCC_RD_CHECK_EN - compare resp_rd_i against the recorded
//               destination register and raise ILLEGAL_INSTR on mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module rocc_dispatch_unit
    import rocc_dispatch_unit_pkg::*;
#(
    parameter int CMD_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int XLEN            = c_XLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     rocc_valid_i,
    output logic                     rocc_ready_o,
    input  logic [31:0]              rocc_instr_i,
    input  fu_data_t                 fu_data_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [31:0]              cmd_instr_o,
    output logic [XLEN-1:0]          cmd_rs1_o,
    output logic [XLEN-1:0]          cmd_rs2_o,
    input  logic                     resp_valid_i,
    output logic                     resp_ready_o,
    input  logic [4:0]               resp_rd_i,
    input  logic [XLEN-1:0]          resp_data_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [XLEN-1:0]          wb_result_o,
    output exception_t               wb_exception_o,
    output logic                     busy_o
);

    localparam int c_CW = $clog2(CMD_DEPTH) + 1;
    localparam int c_TW = $clog2(MAX_OUTSTANDING) + 1;

    rocc_cmd_t        w_cmd_in;
    rocc_cmd_t        w_cmd_head;
    logic             w_cmd_full;
    logic             w_cmd_empty;
    logic [c_CW-1:0]  w_cmd_count;

    rocc_tag_t        w_tag_in;
    rocc_tag_t        w_tag_head;
    logic             w_tag_full;
    logic             w_tag_empty;
    logic [c_TW-1:0]  w_tag_count;

    logic [c_CW-1:0]  r_queued_xd;
    logic [c_TW-1:0]  r_squash_cnt;
    logic             r_resp_ready;

    logic             w_xd_in;
    logic             w_accept;
    logic             w_head_hold;
    logic             w_dispatch;
    logic             w_tag_push;
    logic             w_resp_hs;
    logic             w_resp_pop;
    logic             w_squash_head;
    logic             w_rd_mismatch;
    logic [31:0]      w_credits_used;

    logic                     r_wb_valid;
    logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
    logic [XLEN-1:0]          r_wb_result;
    exception_t               r_wb_exception;
    logic                     w_wb_valid_d;
    logic [TRANS_ID_BITS-1:0] w_wb_trans_id_d;
    logic [XLEN-1:0]          w_wb_result_d;
    exception_t               w_wb_exception_d;

    logic w_unused_misc;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    assign w_xd_in = rocc_instr_i[ROCC_XD_BIT];

    // Credits count both answered-pending commands and xd=1 commands still
    // queued, so a queued xd=1 command is always guaranteed a tag slot.
    assign w_credits_used = 32'(w_tag_count) + 32'(r_queued_xd);
    assign rocc_ready_o   = !w_cmd_full && (w_credits_used < 32'(MAX_OUTSTANDING));
    assign w_accept       = rocc_valid_i && rocc_ready_o && !flush_i;

    assign w_cmd_in.instr    = rocc_instr_i;
    assign w_cmd_in.rs1      = fu_data_i.operand_a;
    assign w_cmd_in.rs2      = fu_data_i.operand_b;
    assign w_cmd_in.trans_id = fu_data_i.trans_id;
    assign w_cmd_in.xd       = w_xd_in;

    rocc_fifo #(
        .DEPTH (CMD_DEPTH),
        .T     (rocc_cmd_t)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_accept),
        .data_i  (w_cmd_in),
        .pop_i   (w_dispatch),
        .data_o  (w_cmd_head),
        .full_o  (w_cmd_full),
        .empty_o (w_cmd_empty),
        .count_o (w_cmd_count)
    );

    // ------------------------------------------------------------------
    // Accelerator command channel
    // ------------------------------------------------------------------
    // An xd=0 head would write back in the same cycle a response might,
    // so it waits out any cycle carrying a response.
    assign w_head_hold = !w_cmd_head.xd && resp_valid_i;
    assign cmd_valid_o = !w_cmd_empty && !w_head_hold && !flush_i;
    assign w_dispatch  = cmd_valid_o && cmd_ready_i;
    assign cmd_instr_o = w_cmd_head.instr;
    assign cmd_rs1_o   = w_cmd_head.rs1;
    assign cmd_rs2_o   = w_cmd_head.rs2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_queued_xd <= '0;
        end else if (flush_i) begin
            r_queued_xd <= '0;
        end else begin
            r_queued_xd <= r_queued_xd
                         + c_CW'(w_accept && w_xd_in)
                         - c_CW'(w_dispatch && w_cmd_head.xd);
        end
    end

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    assign w_tag_push        = w_dispatch && w_cmd_head.xd;
    assign w_tag_in.trans_id = w_cmd_head.trans_id;
    assign w_tag_in.rd       = w_cmd_head.instr[11:7];
    assign w_tag_in.squash   = 1'b0;

    rocc_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (rocc_tag_t)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .push_i  (w_tag_push),
        .data_i  (w_tag_in),
        .pop_i   (w_resp_pop),
        .data_o  (w_tag_head),
        .full_o  (w_tag_full),
        .empty_o (w_tag_empty),
        .count_o (w_tag_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_resp_ready <= 1'b0;
        else         r_resp_ready <= 1'b1;
    end
    assign resp_ready_o = r_resp_ready;

    assign w_resp_hs  = resp_valid_i && r_resp_ready;
    assign w_resp_pop = w_resp_hs && !w_tag_empty;

    // Squashed entries always form a prefix of the tag queue (no tags are
    // pushed during a flush), so marking them is a count of how many head
    // entries remain squashed. A response in the flush cycle is squashed too.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_squash_cnt <= '0;
        end else if (flush_i) begin
            r_squash_cnt <= w_tag_count - c_TW'(w_resp_pop);
        end else if (w_resp_pop && (r_squash_cnt != '0)) begin
            r_squash_cnt <= r_squash_cnt - 1'b1;
        end
    end

    assign w_squash_head = w_tag_head.squash || (r_squash_cnt != '0) || flush_i;

`ifdef ROCC_RD_CHECK_EN
    assign w_rd_mismatch = (resp_rd_i != w_tag_head.rd);
    assign w_unused_misc = ^{w_cmd_count, w_tag_full};
`else
    assign w_rd_mismatch = 1'b0;
    assign w_unused_misc = ^{w_cmd_count, w_tag_full, resp_rd_i, w_tag_head.rd};
`endif

    // ------------------------------------------------------------------
    // Registered write-back
    // ------------------------------------------------------------------
    always_comb begin
        w_wb_valid_d     = 1'b0;
        w_wb_trans_id_d  = r_wb_trans_id;
        w_wb_result_d    = r_wb_result;
        w_wb_exception_d = '0;
        if (w_resp_pop && !w_squash_head) begin
            w_wb_valid_d    = 1'b1;
            w_wb_trans_id_d = w_tag_head.trans_id;
            if (w_rd_mismatch) begin
                w_wb_result_d          = '0;
                w_wb_exception_d.valid = 1'b1;
                w_wb_exception_d.cause = ILLEGAL_INSTR;
                w_wb_exception_d.tval  = '0;
            end else begin
                w_wb_result_d = resp_data_i;
            end
        end else if (w_dispatch && !w_cmd_head.xd) begin
            w_wb_valid_d    = 1'b1;
            w_wb_trans_id_d = w_cmd_head.trans_id;
            w_wb_result_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wb_valid     <= 1'b0;
            r_wb_trans_id  <= '0;
            r_wb_result    <= '0;
            r_wb_exception <= '0;
        end else begin
            r_wb_valid     <= w_wb_valid_d;
            r_wb_trans_id  <= w_wb_trans_id_d;
            r_wb_result    <= w_wb_result_d;
            r_wb_exception <= w_wb_exception_d;
        end
    end

    assign wb_valid_o     = r_wb_valid;
    assign wb_trans_id_o  = r_wb_trans_id;
    assign wb_result_o    = r_wb_result;
    assign wb_exception_o = r_wb_exception;

    assign busy_o = !w_cmd_empty || (w_tag_count != '0);

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; flag it in simulation.
    a_resp_has_tag : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (resp_valid_i && resp_ready_o) |-> !w_tag_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rocc_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rocc_dispatch_unit
// Description : Self-checking bench for rocc_dispatch_unit. Directed
//               scenarios followed by random traffic, all compared each
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rocc_dispatch_unit;
    import rocc_dispatch_unit_pkg::*;

    localparam int CMD_DEPTH = 2;
    localparam int MAX_OUT   = 4;
    localparam int XLEN      = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                     flush;
    logic                     rocc_valid;
    logic                     rocc_ready;
    logic [31:0]              rocc_instr;
    fu_data_t                 fu_data;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [31:0]              cmd_instr;
    logic [XLEN-1:0]          cmd_rs1;
    logic [XLEN-1:0]          cmd_rs2;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [4:0]               resp_rd;
    logic [XLEN-1:0]          resp_data;
    logic                     wb_valid;
    logic [TRANS_ID_BITS-1:0] wb_trans_id;
    logic [XLEN-1:0]          wb_result;
    exception_t               wb_exception;
    logic                     busy;

    rocc_dispatch_unit #(
        .CMD_DEPTH       (CMD_DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .XLEN            (XLEN)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .rocc_valid_i   (rocc_valid),
        .rocc_ready_o   (rocc_ready),
        .rocc_instr_i   (rocc_instr),
        .fu_data_i      (fu_data),
        .cmd_valid_o    (cmd_valid),
        .cmd_ready_i    (cmd_ready),
        .cmd_instr_o    (cmd_instr),
        .cmd_rs1_o      (cmd_rs1),
        .cmd_rs2_o      (cmd_rs2),
        .resp_valid_i   (resp_valid),
        .resp_ready_o   (resp_ready),
        .resp_rd_i      (resp_rd),
        .resp_data_i    (resp_data),
        .wb_valid_o     (wb_valid),
        .wb_trans_id_o  (wb_trans_id),
        .wb_result_o    (wb_result),
        .wb_exception_o (wb_exception),
        .busy_o         (busy)
    );

    // Reference model: pending commands and outstanding response tags.
    typedef struct {
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  id;
    } m_cmd_t;

    typedef struct {
        logic [2:0] id;
        logic [4:0] rd;
        bit         sq;
    } m_tag_t;

    m_cmd_t      cmd_q[$];
    m_tag_t      tag_q[$];
    bit          exp_wb_v  = 1'b0;
    logic [2:0]  exp_wb_id = '0;
    logic [63:0] exp_wb_res = '0;
    bit          exp_exc_v = 1'b0;
    bit          model_rr  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit model_ready();
        int xq = 0;
        foreach (cmd_q[i]) if (cmd_q[i].instr[14]) xq++;
        return (cmd_q.size() < CMD_DEPTH) && ((tag_q.size() + xq) < MAX_OUT);
    endfunction

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model by the events of the coming rising edge.
    task automatic step(input bit v, input logic [31:0] instr, input logic [2:0] id,
                        input logic [63:0] a, input logic [63:0] b, input bit cr,
                        input bit rv, input logic [4:0] rrd, input logic [63:0] rdata,
                        input bit fl);
        bit     rdy;
        bit     dv;
        bit     hold;
        m_cmd_t c;
        m_tag_t t;
        rocc_valid         = v;
        rocc_instr         = instr;
        fu_data.operand_a  = a;
        fu_data.operand_b  = b;
        fu_data.trans_id   = id;
        cmd_ready          = cr;
        resp_valid         = rv;
        resp_rd            = rrd;
        resp_data          = rdata;
        flush              = fl;
        #1;
        rdy  = model_ready();
        hold = (cmd_q.size() > 0) && !cmd_q[0].instr[14] && rv;
        dv   = (cmd_q.size() > 0) && !hold && !fl;
        check("rocc_ready", 64'(rocc_ready), 64'(rdy));
        check("cmd_valid", 64'(cmd_valid), 64'(dv));
        if (dv) begin
            check("cmd_instr", 64'(cmd_instr), 64'(cmd_q[0].instr));
            check("cmd_rs1", cmd_rs1, cmd_q[0].a);
            check("cmd_rs2", cmd_rs2, cmd_q[0].b);
        end
        check("busy", 64'(busy), 64'((cmd_q.size() > 0) || (tag_q.size() > 0)));
        check("resp_ready", 64'(resp_ready), 64'(model_rr));
        check("wb_valid", 64'(wb_valid), 64'(exp_wb_v));
        if (exp_wb_v) begin
            check("wb_trans_id", 64'(wb_trans_id), 64'(exp_wb_id));
            check("wb_result", wb_result, exp_wb_res);
            check("wb_exc_valid", 64'(wb_exception.valid), 64'(exp_exc_v));
            if (exp_exc_v) begin
                check("wb_exc_cause", wb_exception.cause, 64'd2);
                check("wb_exc_tval", wb_exception.tval, 64'd0);
            end
        end
        // Advance model
        exp_wb_v = 1'b0;
        if (rv && model_rr && (tag_q.size() > 0)) begin
            t = tag_q.pop_front();
            if (!t.sq && !fl) begin
                exp_wb_v  = 1'b1;
                exp_wb_id = t.id;
`ifdef ROCC_RD_CHECK_EN
                if (rrd != t.rd) begin
                    exp_wb_res = 64'd0;
                    exp_exc_v  = 1'b1;
                end else begin
                    exp_wb_res = rdata;
                    exp_exc_v  = 1'b0;
                end
`else
                exp_wb_res = rdata;
                exp_exc_v  = 1'b0;
`endif
            end
        end
        if (dv && cr) begin
            c = cmd_q.pop_front();
            if (c.instr[14]) begin
                tag_q.push_back('{c.id, c.instr[11:7], 1'b0});
            end else begin
                exp_wb_v   = 1'b1;
                exp_wb_id  = c.id;
                exp_wb_res = 64'd0;
                exp_exc_v  = 1'b0;
            end
        end
        if (fl) begin
            cmd_q.delete();
            foreach (tag_q[i]) begin
                m_tag_t tmp;
                tmp       = tag_q[i];
                tmp.sq    = 1'b1;
                tag_q[i]  = tmp;
            end
        end else if (v && rdy) begin
            cmd_q.push_back('{instr, a, b, id});
        end
        model_rr = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input bit cr);
        step(1'b0, 32'd0, 3'd0, 64'd0, 64'd0, cr, 1'b0, 5'd0, 64'd0, 1'b0);
    endtask

    task automatic respond(input logic [4:0] rrd, input logic [63:0] rdata);
        step(1'b0, 32'd0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b1, rrd, rdata, 1'b0);
    endtask

    initial begin
        flush      = 1'b0;
        rocc_valid = 1'b0;
        rocc_instr = '0;
        fu_data    = '0;
        cmd_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rd    = '0;
        resp_data  = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_ready", 64'(resp_ready), 64'd0);
        check("rst_wb_result", wb_result, 64'd0);
        check("rst_exc_valid", 64'(wb_exception.valid), 64'd0);
        rst_n = 1'b1;

        // xd=0 command: dispatched at cycle 1, zero write-back at cycle 2
        step(1'b1, 32'h0000200B, 3'd3, 64'h11, 64'h22, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // xd=1 command, response two cycles later
        step(1'b1, 32'h0000708B, 3'd5, 64'h33, 64'h44, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        respond(5'd1, 64'hDEAD_BEEF);
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: third accept stalls on a full command FIFO
        step(1'b1, 32'h0000200B, 3'd1, 64'h1, 64'h2, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b1, 32'h0000208B, 3'd2, 64'h3, 64'h4, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b1, 32'h0000210B, 3'd4, 64'h5, 64'h6, 1'b0, 1'b0, 5'd0, 64'd0, 1'b0);
        check("stall_ready", 64'(rocc_ready), 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Fill the outstanding budget with xd=1 commands, no responses
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'h0000708B, 3'(i), 64'(i), 64'(i + 7), 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        idle(1'b1);
        check("outst_full_ready", 64'(rocc_ready), 64'd0);
        respond(5'd1, 64'hA0);
        idle(1'b1);
        for (int i = 0; i < 3; i++) respond(5'd1, 64'(i + 64'hB0));
        idle(1'b1);
        idle(1'b1);

        // Flush with two outstanding: responses consumed, no write-back
        step(1'b1, 32'h0000708B, 3'd6, 64'h7, 64'h8, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        step(1'b1, 32'h0000708B, 3'd7, 64'h9, 64'hA, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        step(1'b0, 32'd0, 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 5'd0, 64'd0, 1'b1);
        respond(5'd1, 64'hC0);
        respond(5'd1, 64'hC1);
        idle(1'b1);
        idle(1'b1);
        check("flush_busy", 64'(busy), 64'd0);

        // Destination mismatch
        step(1'b1, 32'h0000708B, 3'd2, 64'h1, 64'h1, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        respond(5'd2, 64'h1234);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            bit          rv;
            logic [4:0]  rrd;
            logic [31:0] ins;
            rv  = (tag_q.size() > 0) && ($urandom_range(0, 2) == 0);
            rrd = (tag_q.size() > 0) ? tag_q[0].rd : 5'd0;
            if ($urandom_range(0, 7) == 0) rrd = 5'($urandom);
            ins = $urandom;
            step($urandom_range(0, 1) == 1, ins, 3'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 2) != 0, rv, rrd,
                 {$urandom, $urandom}, $urandom_range(0, 39) == 0);
        end

        // Drain, bounded
        for (int n = 0; n < 200 && ((cmd_q.size() > 0) || (tag_q.size() > 0)); n++) begin
            if (tag_q.size() > 0) respond(tag_q[0].rd, 64'(n));
            else idle(1'b1);
        end
        check("drain_done", 64'((cmd_q.size() == 0) && (tag_q.size() == 0)), 64'd1);
        idle(1'b1);
        idle(1'b1);
        check("final_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rocc_dispatch_unit.md
Name: rocc_dispatch_unit

Overview:
- Downstream of the issue stage; consumes the RoCC issue handshake (instruction word plus operands) and buffers commands in a small FIFO.
- Drives the accelerator command channel, tracks responses expected from instructions with xd=1, and returns results to the scoreboard on a dedicated write-back port.
- Instructions with xd=0 write back zero once their command has been accepted by the accelerator.

Parameters:
- CMD_DEPTH, 2: command FIFO entries (power of two, at least 2).
- MAX_OUTSTANDING, 4: xd=1 commands issued but not yet answered (power of two).
- XLEN, 64: operand and result width (riscv::XLEN).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop unsent commands; squash write-back of outstanding ones
- rocc_valid_i  in  1  issue-stage command valid
- rocc_ready_o  out  1  unit can accept a command
- rocc_instr_i  in  32  raw instruction
- fu_data_i  in  fu_data_t  operand_a=rs1, operand_b=rs2, trans_id
- cmd_valid_o  out  1  command to accelerator
- cmd_ready_i  in  1  accelerator accepts
- cmd_instr_o  out  32  instruction
- cmd_rs1_o  out  XLEN  rs1 value
- cmd_rs2_o  out  XLEN  rs2 value
- resp_valid_i  in  1  accelerator response
- resp_ready_o  out  1  always 1 after reset
- resp_rd_i  in  5  response destination register
- resp_data_i  in  XLEN  response data
- wb_valid_o  out  1  write-back valid
- wb_trans_id_o  out  TRANS_ID_BITS  scoreboard id
- wb_result_o  out  XLEN  result
- wb_exception_o  out  exception_t  write-back exception (valid=0 unless checked mismatch)
- busy_o  out  1  FIFO non-empty or outstanding count non-zero

Behaviour:
- Reset: FIFOs empty, counters 0, all valids 0, wb_result_o 0, busy_o 0, resp_ready_o 0 during reset.
- Accept when rocc_valid_i && rocc_ready_o.
  - rocc_ready_o = !cmd_full && (outstanding + queued_xd < MAX_OUTSTANDING); combinational from registered state only.
  - The accepted entry stores instr, rs1, rs2, trans_id, and xd = instr[14].
- Dispatch: cmd_valid_o = FIFO non-empty. Fields come from the FIFO head, so the earliest cmd_valid_o is one cycle after acceptance.
  - Exception: an xd=0 head is held (cmd_valid_o=0) in any cycle with resp_valid_i=1, which keeps the write-back port conflict-free.
- Tag FIFO: on a cmd handshake of an xd=1 command, push {trans_id, rd=instr[11:7], squash=0}. Depth is MAX_OUTSTANDING; responses are returned in order.
- Write-back is registered, one cycle after the event:
  - xd=1: response handshake pops the tag head; next cycle wb_valid_o=1 with the stored trans_id and resp_data_i, unless squash=1.
  - xd=0: cmd handshake produces, next cycle, wb_valid_o=1 with wb_result_o=0.
- Response with tag FIFO empty: ignore, no write-back; simulation assertion fires.
- Flush:
  - The command FIFO clears the same cycle.
  - All tag entries get squash=1; their responses are still consumed but produce no write-back.
  - A registered wb_valid_o already in flight completes.
  - Accept and dispatch are suppressed in the flush cycle.
- Simultaneous accept and dispatch with a full FIFO: the accept is disallowed because ready derives from pre-dispatch state.
- Pointer wrap: modulo depth, with an extra wrap bit distinguishing full from empty.
- Reset mid-transfer: all state clears asynchronously; in-flight accelerator state is outside scope.

Optional Feature:
- Macro ROCC_RD_CHECK_EN.
- Defined: the response's resp_rd_i is compared with the stored rd.
  - Mismatch: the write-back carries wb_exception_o.valid=1, cause=ILLEGAL_INSTR, tval=instr-independent 0, and wb_result_o=0.
  - Squashed entries are never flagged.
- Undefined: resp_rd_i is unused and wb_exception_o.valid is always 0.

Decomposition:
- ariane_pkg: rocc_cmd_t {instr, rs1, rs2, trans_id, xd}, rocc_tag_t {trans_id, rd, squash}, and constant ROCC_XD_BIT=14.
- Sub-module rocc_fifo (parameterised depth/type, flush input) is instantiated twice: once for commands, once for tags.

Test Plan:
- Accept xd=0 instr 0x0000200B, trans_id 3, cmd_ready_i=1 -> cmd_valid_o at cycle 1, wb_valid_o at cycle 2 with trans_id 3, result 0.
- xd=1 instr 0x0000708B (rd=1), trans_id 5; resp 2 cycles later with data 0xDEAD_BEEF -> wb 1 cycle after resp, trans_id 5, result 0xDEADBEEF.
- cmd_ready_i=0 and 3 accepts with CMD_DEPTH=2 -> third stalls (rocc_ready_o=0); release -> commands appear in order on cmd_*.
- Fill MAX_OUTSTANDING=4 xd=1 commands with no response -> rocc_ready_o=0; one response -> ready returns next cycle.
- Two xd=1 outstanding, flush_i pulse, then two responses -> both consumed, no wb_valid_o; busy_o falls after the second response.
- With ROCC_RD_CHECK_EN, rd=1 stored, resp_rd_i=2 -> wb_exception_o.valid=1 with ILLEGAL_INSTR; without the macro -> normal write-back.
